index_fifo: RTL and testbench
=============================

INDEX_FIFO -- requirements
Module: index_fifo

Interface
REQ-001 Parameter BW, default 8, bit width of the word whose set-bit indices are being collected.
REQ-002 Parameter DEPTH, default 8, FIFO depth in entries; SHALL be a power of two >= 2.
REQ-003 Derived IW = $clog2(BW) and CW = $clog2(DEPTH)+1; these SHALL be derived from the parameters, not settable by the user.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst_b  input  1  reset; synchronous, active-low.
REQ-006 in_vld  input  1  index-stream valid from the upstream index-of-one stage; there is no backpressure to upstream.
REQ-007 in_index  input  IW  bit index being delivered; sampled only when in_vld=1.
REQ-008 clr  input  1  synchronous clear of bitmap and ovf; does not flush the FIFO.
REQ-009 out_rdy  input  1  downstream ready.
REQ-010 out_vld  output  1  head entry is valid.
REQ-011 out_index  output  IW  head entry value.
REQ-012 count  output  CW  number of entries held, 0..DEPTH.
REQ-013 full  output  1  count==DEPTH.
REQ-014 empty  output  1  count==0.
REQ-015 ovf  output  1  sticky flag: an index was dropped.
REQ-016 bitmap  output  BW  bit k set once index k has been accepted since the last clr or reset.

Function
REQ-017 Push SHALL occur on a cycle with in_vld=1 when either (count<DEPTH) or (count==DEPTH and a pop occurs on the same cycle).
REQ-018 Pop SHALL occur on a cycle with out_vld=1 and out_rdy=1.
REQ-019 The FIFO SHALL be first-word-fall-through: out_vld=!empty, and out_index SHALL present the oldest entry with no read latency.
REQ-020 A pushed entry SHALL become visible on out_vld/out_index the cycle after the push; push-to-out latency is 1 cycle.
REQ-021 Ordering SHALL be strict FIFO.
REQ-022 Read and write pointers SHALL wrap modulo DEPTH with no lost or duplicated entries across the wrap.
REQ-023 count update: push-only +1; pop-only -1; push and pop together unchanged; neither unchanged.
REQ-024 Empty with in_vld=1: push only, since no pop is possible because out_vld=0; out_vld SHALL rise next cycle.
REQ-025 Full with in_vld=1 and no pop: the index SHALL be dropped, count SHALL stay DEPTH, ovf SHALL be set next cycle, and bitmap SHALL be unchanged by that index.
REQ-026 Full with in_vld=1 and a pop on the same cycle: both SHALL occur; count SHALL stay DEPTH; ovf SHALL NOT be set.
REQ-027 On each accepted push, bitmap[in_index] SHALL be set to 1; no other bit SHALL change.
REQ-028 in_index >= BW (possible only when BW is not a power of two) SHALL be pushed, but SHALL NOT alter bitmap.
REQ-029 clr=1: next cycle, bitmap=0 and ovf=0, except that an index accepted on the same cycle as clr SHALL leave its bit set, and a drop on the same cycle SHALL leave ovf=1 (new event has priority over clr).
REQ-030 clr SHALL NOT affect FIFO contents, count, or pointers.
REQ-031 out_index SHALL be held stable while out_vld=1 and out_rdy=0.
REQ-032 All outputs SHALL be driven from registers or from the registered storage array selected by the registered read pointer; there SHALL be no combinational path from in_vld or in_index to any output.

Reset
REQ-033 While rst_b=0 at a rising edge, the next state SHALL be: count=0, both pointers=0, out_vld=0, empty=1, full=0, ovf=0, bitmap=0.
REQ-034 After reset, out_index SHALL be 0 and the storage contents SHALL be don't-care.
REQ-035 Reset asserted mid-operation SHALL discard all held entries; any push, pop or clr on the reset cycle SHALL be ignored.
REQ-036 Inputs SHALL be honoured from the first rising edge with rst_b=1.

Verification
REQ-037 Burst with out_rdy=0: after reset, in_vld pulses carrying indices 0, 3, 7 on consecutive cycles -> count=3, bitmap=8'b10001001, out_vld=1, out_index=0.
REQ-038 Drain: out_rdy=1 after the burst -> out_index sequence 0, 3, 7 on three successive cycles, then empty=1, out_vld=0, with bitmap still 8'b10001001.
REQ-039 Overflow: out_rdy=0, push 9 indices 0..7 then 2 -> full=1 after the 8th push, 9th dropped, ovf=1, count=8, bitmap=8'hFF; pop order 0..7.
REQ-040 Full with simultaneous push and pop: hold full, out_rdy=1, push index 5 -> count stays 8, ovf stays 0, and 5 emerges after the existing 8 entries.
REQ-041 clr collision: bitmap=8'h0F, clr=1 with an accepted push of index 6 on the same cycle -> bitmap=8'b01000000; FIFO count +1.
REQ-042 Wrap and reset: push and pop 20 entries with out_rdy toggling every cycle -> in-order output, no loss across pointer wrap; then assert rst_b=0 with count=4 -> count=0, empty=1, out_vld=0 next cycle.

Source files
------------

// File: rtl/index_fifo.sv
// Collects set-bit indices into a first-word-fall-through FIFO and records which ones were seen.
// A push appears at the output 1 cycle later. There is no upstream backpressure: an index arriving while the FIFO is full is dropped and sets ovf.
module index_fifo #(
    parameter  int BW    = 8,
    parameter  int DEPTH = 8,
    localparam int IW    = $clog2(BW),
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_b,
    input  logic          in_vld,
    input  logic [IW-1:0] in_index,
    input  logic          clr,
    input  logic          out_rdy,
    output logic          out_vld,
    output logic [IW-1:0] out_index,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty,
    output logic          ovf,
    output logic [BW-1:0] bitmap
);

    localparam int PW = CW - 1;

    logic [IW-1:0]      mem [DEPTH];
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;
    logic               push;
    logic               pop;
    logic               drop;
    logic [CW-1:0]      count_nxt;
    logic [2**IW-1:0]   idx_onehot;

    always_comb begin
        pop        = out_vld & out_rdy;
        // A pop on the same cycle frees the slot, so a full FIFO can still accept.
        push       = in_vld & (~full | pop);
        drop       = in_vld & full & ~pop;
        idx_onehot = '0;
        idx_onehot[in_index] = 1'b1;
        count_nxt  = count;
        case ({push, pop})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(1);
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
            ovf    <= 1'b0;
            bitmap <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count  <= count_nxt;
            full   <= (count_nxt == CW'(DEPTH));
            empty  <= (count_nxt == '0);
            // New events win over a same-cycle clear; indices >= BW fall outside the slice.
            ovf    <= drop | (ovf & ~clr);
            bitmap <= (clr ? '0 : bitmap) | (push ? idx_onehot[BW-1:0] : '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst_b && push) begin
            mem[wr_ptr] <= in_index;
        end
    end

    assign out_vld   = ~empty;
    assign out_index = empty ? '0 : mem[rd_ptr];

endmodule

// File: tb/tb_index_fifo.sv
// Directed bench for index_fifo: vector table plus hand-written overflow, wrap and reset sequences.
module tb_index_fifo;

    localparam int BW    = 8;
    localparam int DEPTH = 8;
    localparam int IW    = 3;
    localparam int CW    = 4;

    logic          clk = 1'b0;
    logic          rst_b;
    logic          in_vld;
    logic [IW-1:0] in_index;
    logic          clr;
    logic          out_rdy;
    logic          out_vld;
    logic [IW-1:0] out_index;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic          ovf;
    logic [BW-1:0] bitmap;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic          r;
        logic          v;
        logic [IW-1:0] idx;
        logic          c;
        logic          rd;
        int            cnt;
        logic          vld;
        logic [IW-1:0] oidx;
        logic          fl;
        logic          em;
        logic          ov;
        logic [BW-1:0] bm;
    } vec_t;

    vec_t          vecs [17];
    logic [IW-1:0] exp_order [8];
    logic [IW-1:0] q [$];

    index_fifo #(.BW(BW), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_b     (rst_b),
        .in_vld    (in_vld),
        .in_index  (in_index),
        .clr       (clr),
        .out_rdy   (out_rdy),
        .out_vld   (out_vld),
        .out_index (out_index),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .ovf       (ovf),
        .bitmap    (bitmap)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic v, input logic [IW-1:0] idx,
                        input logic c, input logic rd);
        rst_b    = r;
        in_vld   = v;
        in_index = idx;
        clr      = c;
        out_rdy  = rd;
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag, input int cnt, input logic vld,
                               input logic [IW-1:0] oidx, input logic fl, input logic em,
                               input logic ov, input logic [BW-1:0] bm);
        check({tag, ".count"},     count,     cnt);
        check({tag, ".out_vld"},   out_vld,   vld);
        check({tag, ".out_index"}, out_index, oidx);
        check({tag, ".full"},      full,      fl);
        check({tag, ".empty"},     empty,     em);
        check({tag, ".ovf"},       ovf,       ov);
        check({tag, ".bitmap"},    bitmap,    bm);
    endtask

    initial begin
        int pushed;
        int popped;
        int cyc;
        logic v;
        logic rd;
        logic do_pop;

        //             r  v  idx c  rd  cnt vld oidx fl em ov bitmap
        vecs[0]  = '{1'b0,1'b0,3'd0,1'b0,1'b0, 0,1'b0,3'd0,1'b0,1'b1,1'b0,8'h00};
        vecs[1]  = '{1'b1,1'b1,3'd0,1'b0,1'b0, 1,1'b1,3'd0,1'b0,1'b0,1'b0,8'h01};
        vecs[2]  = '{1'b1,1'b1,3'd3,1'b0,1'b0, 2,1'b1,3'd0,1'b0,1'b0,1'b0,8'h09};
        vecs[3]  = '{1'b1,1'b1,3'd7,1'b0,1'b0, 3,1'b1,3'd0,1'b0,1'b0,1'b0,8'h89};
        vecs[4]  = '{1'b1,1'b0,3'd0,1'b0,1'b0, 3,1'b1,3'd0,1'b0,1'b0,1'b0,8'h89};
        vecs[5]  = '{1'b1,1'b0,3'd0,1'b0,1'b1, 2,1'b1,3'd3,1'b0,1'b0,1'b0,8'h89};
        vecs[6]  = '{1'b1,1'b0,3'd0,1'b0,1'b1, 1,1'b1,3'd7,1'b0,1'b0,1'b0,8'h89};
        vecs[7]  = '{1'b1,1'b0,3'd0,1'b0,1'b1, 0,1'b0,3'd0,1'b0,1'b1,1'b0,8'h89};
        vecs[8]  = '{1'b1,1'b0,3'd0,1'b1,1'b0, 0,1'b0,3'd0,1'b0,1'b1,1'b0,8'h00};
        vecs[9]  = '{1'b1,1'b1,3'd0,1'b0,1'b0, 1,1'b1,3'd0,1'b0,1'b0,1'b0,8'h01};
        vecs[10] = '{1'b1,1'b1,3'd1,1'b0,1'b0, 2,1'b1,3'd0,1'b0,1'b0,1'b0,8'h03};
        vecs[11] = '{1'b1,1'b1,3'd2,1'b0,1'b0, 3,1'b1,3'd0,1'b0,1'b0,1'b0,8'h07};
        vecs[12] = '{1'b1,1'b1,3'd3,1'b0,1'b0, 4,1'b1,3'd0,1'b0,1'b0,1'b0,8'h0F};
        vecs[13] = '{1'b1,1'b1,3'd6,1'b1,1'b0, 5,1'b1,3'd0,1'b0,1'b0,1'b0,8'h40};
        vecs[14] = '{1'b1,1'b0,3'd0,1'b0,1'b1, 4,1'b1,3'd1,1'b0,1'b0,1'b0,8'h40};
        vecs[15] = '{1'b0,1'b1,3'd5,1'b1,1'b1, 0,1'b0,3'd0,1'b0,1'b1,1'b0,8'h00};
        vecs[16] = '{1'b1,1'b0,3'd0,1'b0,1'b0, 0,1'b0,3'd0,1'b0,1'b1,1'b0,8'h00};

        exp_order = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd5};

        rst_b = 1'b0; in_vld = 1'b0; in_index = '0; clr = 1'b0; out_rdy = 1'b0;

        for (int i = 0; i < 17; i++) begin
            step(vecs[i].r, vecs[i].v, vecs[i].idx, vecs[i].c, vecs[i].rd);
            check_state($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].vld, vecs[i].oidx,
                        vecs[i].fl, vecs[i].em, vecs[i].ov, vecs[i].bm);
        end

        // Fill to full, overflow, clear/drop priority, then push+pop while full.
        step(1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b1, 3'(i), 1'b0, 1'b0);
            check($sformatf("fill%0d.count", i), count, i + 1);
            check($sformatf("fill%0d.full", i), full, (i == 7));
        end
        step(1'b1, 1'b1, 3'd2, 1'b0, 1'b0);
        check_state("ovf", 8, 1'b1, 3'd0, 1'b1, 1'b0, 1'b1, 8'hFF);
        step(1'b1, 1'b1, 3'd2, 1'b1, 1'b0);
        check_state("clr_drop", 8, 1'b1, 3'd0, 1'b1, 1'b0, 1'b1, 8'h00);
        step(1'b1, 1'b0, 3'd0, 1'b1, 1'b0);
        check_state("clr_only", 8, 1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b1, 3'd5, 1'b0, 1'b1);
        check_state("full_pushpop", 8, 1'b1, 3'd1, 1'b1, 1'b0, 1'b0, 8'h20);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("drain%0d.out_index", k), out_index, exp_order[k]);
            step(1'b1, 1'b0, 3'd0, 1'b0, 1'b1);
        end
        check_state("drained", 0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 8'h20);

        // Pointer wrap: 20 entries, out_rdy toggling every cycle, checked against a queue.
        pushed = 0;
        popped = 0;
        cyc    = 0;
        q.delete();
        while (popped < 20 && cyc < 200) begin
            v      = (pushed < 20) && (q.size() < 6);
            rd     = cyc[0];
            do_pop = (q.size() > 0) && rd;
            check($sformatf("wrap%0d.out_vld", cyc), out_vld, (q.size() > 0));
            if (q.size() > 0) begin
                check($sformatf("wrap%0d.out_index", cyc), out_index, q[0]);
            end
            step(1'b1, v, 3'((pushed * 3) % 8), 1'b0, rd);
            if (do_pop) begin
                void'(q.pop_front());
                popped++;
            end
            if (v) begin
                q.push_back(3'((pushed * 3) % 8));
                pushed++;
            end
            check($sformatf("wrap%0d.count", cyc), count, q.size());
            cyc++;
        end
        check("wrap.popped", popped, 20);
        check("wrap.ovf", ovf, 1'b0);

        // Reset mid-operation with four entries held.
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1, 3'(i + 2), 1'b0, 1'b0);
        end
        check("pre_rst.count", count, 4);
        check("pre_rst.out_index", out_index, 3'd2);
        step(1'b0, 1'b1, 3'd5, 1'b1, 1'b1);
        check_state("mid_rst", 0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b0, 3'd0, 1'b0, 1'b1);
        check_state("post_rst", 0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
